// File: rtl/crc4fsk_pkg.sv
// Shared constants and state encoding for the CRC/4FSK transmit frame path.
package crc4fsk_pkg;

    localparam logic [7:0]  CRC_POLY      = 8'h07;
    localparam logic [7:0]  CRC_INIT      = 8'h00;
    localparam int unsigned SYMS_PER_BYTE = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        CRC,
        DONE
    } state_t;

endpackage

// File: rtl/crc8_byte_update.sv
// One-byte CRC-8 step (MSB-first, no reflection), shared by the TX sequencer and RX checker.
module crc8_byte_update
    import crc4fsk_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] w_crc;

    always_comb begin
        w_crc = crc_in ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            w_crc = w_crc[7] ? ((w_crc << 1) ^ CRC_POLY) : (w_crc << 1);
        end
        crc_out = w_crc;
    end

endmodule

// File: rtl/crc4fsk_frame_ctrl.sv
// Frame sequencer: pulls payload bytes, emits each as four held 2-bit symbols,
// then appends the running CRC-8 as the final four symbols.
module crc4fsk_frame_ctrl
    import crc4fsk_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES = 4,
    parameter int unsigned SYM_CYCLES    = 4
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] sym_out,
    output logic       sym_valid,
    output logic       sym_strobe,
    output logic       busy,
    output logic       done,
    output logic [7:0] crc_out
);

    localparam int unsigned BW = $clog2(PAYLOAD_BYTES) + 1;
    localparam int unsigned HW = $clog2(SYM_CYCLES) + 1;
    localparam logic [BW-1:0] BYTE_LAST = BW'(PAYLOAD_BYTES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(SYM_CYCLES - 1);
    localparam logic [1:0]    SYM_LAST  = 2'(SYMS_PER_BYTE - 1);

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_crc;
    logic [7:0]      r_crc_out;
    logic [7:0]      r_shreg;
    logic [BW-1:0]   r_byte_cnt;
    logic [HW-1:0]   r_hold_cnt;
    logic [1:0]      r_sym_idx;
    logic [7:0]      w_crc_next;
    logic            w_live;
    logic            w_sym_last;
    logic            w_byte_end;

    crc8_byte_update u_crc (
        .crc_in  (r_crc),
        .data    (in_data),
        .crc_out (w_crc_next)
    );

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_live     = (r_state == SEND) || (r_state == CRC);
        w_sym_last = (r_hold_cnt == HOLD_LAST);
        w_byte_end = w_sym_last && (r_sym_idx == SYM_LAST);
        w_next     = r_state;
        in_ready   = 1'b0;
        sym_valid  = w_live;
        sym_out    = w_live ? r_shreg[7:6] : 2'b00;
        sym_strobe = w_live && (r_hold_cnt == '0);
        busy       = (r_state != IDLE);
        done       = (r_state == DONE);
        crc_out    = r_crc_out;

        case (r_state)
            IDLE: if (start) w_next = LOAD;
            LOAD: begin
                in_ready = !abort;
                if (in_valid) w_next = SEND;
            end
            SEND: if (w_byte_end) w_next = (r_byte_cnt == BYTE_LAST) ? CRC : LOAD;
            CRC:  if (w_byte_end) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase

        // abort outranks every transition, including start and a byte accept
        if (abort) w_next = IDLE;
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_crc      <= '0;
            r_crc_out  <= '0;
            r_shreg    <= '0;
            r_byte_cnt <= '0;
            r_hold_cnt <= '0;
            r_sym_idx  <= '0;
        end else if (!abort) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_crc      <= CRC_INIT;
                        r_byte_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        r_shreg    <= in_data;
                        r_crc      <= w_crc_next;
                        r_hold_cnt <= '0;
                        r_sym_idx  <= '0;
                    end
                end
                SEND, CRC: begin
                    if (w_sym_last) begin
                        r_hold_cnt <= '0;
                        r_shreg    <= r_shreg << 2;
                        r_sym_idx  <= r_sym_idx + 2'd1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                    if (w_byte_end) begin
                        if (r_state == CRC) begin
                            r_crc_out <= r_crc;
                        end else if (r_byte_cnt == BYTE_LAST) begin
                            r_shreg <= r_crc;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
